// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader: collects a byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until loading finishes.
module imem_boot_ctrl #(
    parameter int DW             = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_WORDS    = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int LW             = $clog2(NO_OF_WORDS) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [LW-1:0] MAX_LEN = LW'(NO_OF_WORDS);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   word_q, word_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_ok_s;
    logic [LW-1:0] word_cnt_inc_s;

    assign start_ok_s     = (len_i != {LW{1'b0}}) && (len_i <= MAX_LEN);
    assign word_cnt_inc_s = word_cnt_q + {{(LW-1){1'b0}}, 1'b1};

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start_i) begin
                    if (start_ok_s) begin
                        state_d    = ST_LOAD;
                        len_d      = len_i;
                        word_cnt_d = {LW{1'b0}};
                        byte_cnt_d = 2'd0;
                        word_d     = 32'd0;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (byte_valid_i) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // The write strobe is launched here so it is a flop output during COMMIT
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = ST_COMMIT;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = DW'({word_cnt_q, 2'b00});
                        mem_wdata_d = DW'(word_d);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                word_cnt_d = word_cnt_inc_s;
                if (word_cnt_inc_s == len_q) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= {LW{1'b0}};
            word_cnt_q  <= {LW{1'b0}};
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {DW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign byte_ready_o = (state_q == ST_LOAD);
    assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
    assign core_rst_o   = (state_q != ST_RUN);
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_imem_boot_ctrl;

    localparam int DW = 32;
    localparam int LW = 9;
    localparam int NW = 256;

    typedef logic [7:0] bq_t[$];

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          core_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic [63:0] wlog[$];

    imem_boot_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .core_rst_o(core_rst_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: load progress expressed as a byte queue and a word tally
    localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2, M_RUN = 3;
    int          m_phase = M_IDLE;
    int          m_len   = 0;
    int          m_words = 0;
    logic [7:0]  m_bytes[$];
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;

    function automatic logic [31:0] word_of(input bq_t b, input int k);
        return 32'(b[4*k]) + 32'(b[4*k+1]) * 32'd256 + 32'(b[4*k+2]) * 32'd65536
             + 32'(b[4*k+3]) * 32'd16777216;
    endfunction

    task automatic model_step();
        if (rst_i) begin
            m_phase = M_IDLE; m_words = 0; m_bytes.delete();
            m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_we = 1'b0;
            m_done = 1'b0;
            if (m_phase == M_IDLE || m_phase == M_RUN) begin
                if (start_i) begin
                    if (int'(len_i) >= 1 && int'(len_i) <= NW) begin
                        m_len = int'(len_i); m_words = 0; m_bytes.delete();
                        m_err = 1'b0; m_phase = M_LOAD;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_phase == M_LOAD) begin
                if (byte_valid_i) begin
                    m_bytes.push_back(byte_data_i);
                    if (m_bytes.size() == 4) begin
                        m_we = 1'b1;
                        m_addr = 32'(m_words * 4);
                        m_wdata = word_of(m_bytes, 0);
                        m_bytes.delete();
                        m_phase = M_COMMIT;
                    end
                end
            end else begin
                m_words++;
                if (m_words == m_len) begin
                    m_phase = M_RUN;
                    m_done = 1'b1;
                end else begin
                    m_phase = M_LOAD;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    // Per-cycle comparison against the model and capture of memory writes
    initial forever begin
        @(negedge clk_i);
        if (chk_en) begin
            check("byte_ready", 32'(byte_ready_o), 32'(m_phase == M_LOAD));
            check("busy", 32'(busy_o), 32'(m_phase == M_LOAD || m_phase == M_COMMIT));
            check("core_rst", 32'(core_rst_o), 32'(m_phase != M_RUN));
            check("mem_we", 32'(mem_we_o), 32'(m_we));
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_wdata", mem_wdata_o, m_wdata);
            check("done", 32'(done_o), 32'(m_done));
            check("err", 32'(err_o), 32'(m_err));
            if (mem_we_o === 1'b1) wlog.push_back({mem_addr_o, mem_wdata_o});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_load(input int len);
        start_i = 1'b1;
        len_i = LW'(len);
        tick();
        start_i = 1'b0;
        len_i = LW'($urandom);
    endtask

    task automatic send_bytes(input bq_t b, input int gap_pct);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < b.size() && guard < 20000) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                byte_valid_i = 1'b0;
                byte_data_i = 8'($urandom);
            end else begin
                byte_valid_i = 1'b1;
                byte_data_i = b[i];
            end
            @(negedge clk_i);
            acc = byte_valid_i && (byte_ready_o === 1'b1);
            tick();
            if (acc) i++;
            guard++;
        end
        byte_valid_i = 1'b0;
        if (i < b.size()) timeout("send_bytes");
    endtask

    task automatic wait_run(input int limit);
        int n = 0;
        while (core_rst_o !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (core_rst_o !== 1'b0) timeout("wait_run");
    endtask

    task automatic rand_bytes(output bq_t b, input int n);
        b.delete();
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    task automatic check_log(input string name, input bq_t b, input int nwords);
        check({name, "_count"}, 32'(wlog.size()), 32'(nwords));
        for (int k = 0; k < nwords && k < wlog.size(); k++) begin
            check({name, "_addr"}, wlog[k][63:32], 32'(k * 4));
            check({name, "_data"}, wlog[k][31:0], word_of(b, k));
        end
    endtask

    bq_t bytes;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = 8'd0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_core_rst", 32'(core_rst_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single-word program: addi a0, x0, 5
        wlog.delete();
        start_load(1);
        bytes = '{8'h13, 8'h05, 8'h50, 8'h00};
        send_bytes(bytes, 0);
        check("s1_we", 32'(mem_we_o), 32'd1);
        check("s1_addr", mem_addr_o, 32'h0000_0000);
        check("s1_wdata", mem_wdata_o, 32'h0050_0513);
        check("s1_ready_commit", 32'(byte_ready_o), 32'd0);
        tick();
        check("s1_done", 32'(done_o), 32'd1);
        check("s1_core_rst", 32'(core_rst_o), 32'd0);
        tick();
        check("s1_done_pulse", 32'(done_o), 32'd0);
        check("s1_writes", 32'(wlog.size()), 32'd1);

        // Three words with random valid gaps
        wlog.delete();
        rand_bytes(bytes, 12);
        start_load(3);
        send_bytes(bytes, 40);
        wait_run(50);
        check_log("s2", bytes, 3);

        // Rejected starts from IDLE, then a valid one
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        wlog.delete();
        start_load(0);
        check("s3_err_len0", 32'(err_o), 32'd1);
        check("s3_busy_len0", 32'(busy_o), 32'd0);
        start_load(257);
        check("s3_err_len257", 32'(err_o), 32'd1);
        check("s3_busy_len257", 32'(busy_o), 32'd0);
        repeat (3) tick();
        check("s3_no_writes", 32'(wlog.size()), 32'd0);
        start_load(1);
        check("s3_err_clear", 32'(err_o), 32'd0);
        check("s3_busy", 32'(busy_o), 32'd1);
        rand_bytes(bytes, 4);
        send_bytes(bytes, 20);
        wait_run(20);
        check_log("s3", bytes, 1);

        // Full memory load
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        wlog.delete();
        rand_bytes(bytes, 4 * NW);
        start_load(NW);
        send_bytes(bytes, 10);
        wait_run(20);
        repeat (5) tick();
        check_log("s4", bytes, NW);
        if (wlog.size() > 0) check("s4_last_addr", wlog[wlog.size()-1][63:32], 32'h0000_03FC);
        check("s4_run", 32'(core_rst_o), 32'd0);

        // Restart from RUN
        wlog.delete();
        start_load(2);
        check("s5_core_rst", 32'(core_rst_o), 32'd1);
        rand_bytes(bytes, 8);
        send_bytes(bytes, 30);
        wait_run(30);
        check_log("s5", bytes, 2);

        // Reset after two bytes of a word, then a fresh load
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        wlog.delete();
        start_load(2);
        bytes = '{8'hAA, 8'h55};
        send_bytes(bytes, 0);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("s6_we", 32'(mem_we_o), 32'd0);
        check("s6_core_rst", 32'(core_rst_o), 32'd1);
        check("s6_busy", 32'(busy_o), 32'd0);
        repeat (3) tick();
        check("s6_no_writes", 32'(wlog.size()), 32'd0);
        start_load(1);
        bytes = '{8'h93, 8'h00, 8'h10, 8'h00};
        send_bytes(bytes, 0);
        wait_run(10);
        check("s6_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            check("s6_addr", wlog[0][63:32], 32'h0000_0000);
            check("s6_data", wlog[0][31:0], 32'h0010_0093);
        end

        // Randomized soak: starts, bad lengths, resets and byte gaps
        for (int c = 0; c < 3000; c++) begin
            int pick;
            rst_i = ($urandom_range(0, 199) == 0);
            start_i = ($urandom_range(0, 99) < 6);
            pick = $urandom_range(0, 7);
            len_i = (pick == 0) ? LW'(0) : (pick == 1) ? LW'(257) : (pick == 2) ? LW'(511)
                  : LW'($urandom_range(1, 5));
            byte_valid_i = ($urandom_range(0, 99) < 70);
            byte_data_i = 8'($urandom);
            tick();
        end
        rst_i = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter DW, default 32, SHALL set the data/address width of the memory write port.
REQ-003 Parameter MEM_SIZE_IN_KB, default 1, SHALL set the instruction memory size.
REQ-004 Parameter NO_OF_WORDS, default MEM_SIZE_IN_KB*1024/4 (256), SHALL set the number of loadable words.
REQ-005 Parameter LW, default $clog2(NO_OF_WORDS)+1, SHALL set the width of the length input.
REQ-006 clk_i  input  1  SHALL be the clock; all state updates occur on the rising edge.
REQ-007 rst_i  input  1  SHALL be the synchronous, active-high reset.
REQ-008 start_i  input  1  SHALL request a new program load when high.
REQ-009 len_i  input  LW  SHALL give the program length in words; it is sampled with start_i.
REQ-010 byte_valid_i  input  1  SHALL mark byte_data_i as valid.
REQ-011 byte_data_i  input  8  SHALL carry one program byte, least-significant byte of each word first.
REQ-012 byte_ready_o  output  1  SHALL indicate that the block accepts a byte this cycle.
REQ-013 mem_we_o  output  1  SHALL be the instruction memory write strobe.
REQ-014 mem_addr_o  output  DW  SHALL be the byte address of the write (word index * 4).
REQ-015 mem_wdata_o  output  DW  SHALL be the assembled instruction word.
REQ-016 core_rst_o  output  1  SHALL hold the core (pc, reg_file) in reset while high.
REQ-017 busy_o  output  1  SHALL be high in the LOAD and COMMIT states.
REQ-018 done_o  output  1  SHALL pulse for one cycle when a load completes.
REQ-019 err_o  output  1  SHALL be a sticky flag for a rejected start request.

Function
REQ-020 The FSM SHALL have four states: IDLE, LOAD, COMMIT and RUN.
REQ-021 A byte SHALL transfer on a rising edge where byte_valid_i and byte_ready_o are both high.
REQ-022 byte_ready_o SHALL be high only in LOAD; it SHALL be low in IDLE, COMMIT and RUN.
REQ-023 In IDLE or RUN, start_i with 1 <= len_i <= NO_OF_WORDS SHALL latch len_i, clear the word and byte counters, clear err_o and enter LOAD on the next cycle.
REQ-024 In IDLE or RUN, start_i with len_i == 0 or len_i > NO_OF_WORDS SHALL set err_o and leave the state and counters unchanged.
REQ-025 start_i SHALL be ignored in LOAD and COMMIT.
REQ-026 A 2-bit byte counter SHALL place accepted byte k (k = 0..3) into bits [8k+7:8k] of the word register.
REQ-027 Acceptance of the 4th byte SHALL move the FSM to COMMIT on the next cycle.
REQ-028 In COMMIT, mem_we_o SHALL be high for exactly that one cycle, with mem_addr_o = word_cnt*4 and mem_wdata_o = the assembled word.
REQ-029 When leaving COMMIT, word_cnt SHALL increment.
REQ-030 On leaving COMMIT, the FSM SHALL enter RUN if the incremented count equals the latched length, and LOAD otherwise.
REQ-031 done_o SHALL be high only in the first RUN cycle after COMMIT.
REQ-032 core_rst_o SHALL be 0 only in RUN; it SHALL be 1 in IDLE, LOAD and COMMIT.
REQ-033 A restart from RUN SHALL raise core_rst_o in the first LOAD cycle.
REQ-034 mem_we_o SHALL be 0 outside COMMIT; mem_addr_o and mem_wdata_o SHALL hold their last values.
REQ-035 Bytes SHALL never be lost or duplicated; a LOAD stall of any length on byte_valid_i SHALL be tolerated.
REQ-036 mem_we_o, mem_addr_o, mem_wdata_o, done_o and err_o SHALL be registered.
REQ-037 mem_addr_o SHALL never exceed (NO_OF_WORDS-1)*4.

Reset
REQ-038 On rst_i, the FSM SHALL enter IDLE and all counters and the word register SHALL clear to 0.
REQ-039 On rst_i, byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o and err_o SHALL be 0, and core_rst_o SHALL be 1.
REQ-040 rst_i asserted mid-LOAD or mid-COMMIT SHALL abort the load without a write in the following cycle, and the partial word SHALL be discarded.

Verification
REQ-041 The bench SHALL check: reset, start_i with len_i=1, then bytes 13,05,50,00 (hex) on consecutive cycles -> one mem_we_o cycle with addr 0 and wdata 0x00500513; next cycle RUN, done_o=1 for 1 cycle, core_rst_o=0.
REQ-042 The bench SHALL check: len_i=3 with 12 bytes and random byte_valid_i gaps -> exactly 3 writes at addr 0,4,8 with correct data, and byte_ready_o=0 during each COMMIT.
REQ-043 The bench SHALL check: start_i with len_i=0, then with len_i=257 -> err_o=1, state stays IDLE, no writes; a following valid start -> err_o=0 and busy_o=1.
REQ-044 The bench SHALL check: len_i=256 full load -> last write at addr 0x3FC, then RUN and no address wrap.
REQ-045 The bench SHALL check: in RUN, start_i with len_i=2 -> core_rst_o=1 next cycle and the word count restarts at addr 0.
REQ-046 The bench SHALL check: rst_i after 2 bytes of a word -> no mem_we_o, IDLE, core_rst_o=1; a fresh load then writes the correct word at addr 0.
